// File: rtl/aes_seq_pkg.sv
// Shared definitions for the aes_core sequencer: FSM states, register bit positions and
// the default watchdog limit.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StKinit  = 3'd1,
        StKwait  = 3'd2,
        StFetch  = 3'd3,
        StRcap   = 3'd4,
        StStart  = 3'd5,
        StBwait  = 3'd6,
        StResult = 3'd7
    } seq_state_e;

    localparam int unsigned DefaultTimeout = 200;

    localparam int unsigned CtrlKeyLoadBit    = 0;
    localparam int unsigned CtrlBurstStartBit = 1;
    localparam int unsigned CtrlEncdecBit     = 2;

    localparam int unsigned StatusBusyBit       = 0;
    localparam int unsigned StatusKeyValidBit   = 1;
    localparam int unsigned StatusErrTimeoutBit = 2;
    localparam int unsigned StatusResValidBit   = 3;

endpackage

// File: rtl/aes_core_sequencer_watchdog.sv
// seq_watchdog: counts cycles while enabled and pulses expire on the TIMEOUT-th cycle.
module seq_watchdog #(
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expire = enable && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_core_sequencer.sv
// aes_core_sequencer: runs key expansion, then one aes_core block per command or per LFSR
// burst entry, returning results over valid/ready with a watchdog on every core wait.
module aes_core_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [127:0]     key,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [127:0]     cmd_block,
    input  logic             cmd_encdec,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             rnd_req,
    input  logic [127:0]     rnd_data,
    output logic             core_init,
    output logic             core_next,
    output logic             core_encdec,
    output logic [127:0]     core_key,
    output logic [127:0]     core_block,
    input  logic             core_ready,
    input  logic             core_valid,
    input  logic [127:0]     core_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [127:0]     res_data,
    output logic             busy,
    output logic             key_valid,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err_timeout
);

    seq_state_e       state_q, state_d;
    logic             first_q;
    logic             key_valid_q, key_valid_d;
    logic             err_q, err_d;
    logic             burst_q, burst_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             encdec_q, encdec_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     block_q, block_d;
    logic [127:0]     res_q, res_d;
    logic             wd_enable, wd_expire;

    assign wd_enable = (state_q == StKwait) || (state_q == StBwait);

    seq_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!wd_enable),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        burst_d     = burst_q;
        remain_d    = remain_q;
        blk_cnt_d   = blk_cnt_q;
        encdec_d    = encdec_q;
        key_d       = key_q;
        block_d     = block_q;
        res_d       = res_q;
        cmd_ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_load) begin
                    key_d       = key;
                    key_valid_d = 1'b0;
                    blk_cnt_d   = '0;
                    err_d       = 1'b0;
                    state_d     = StKinit;
                end else if (burst_start && key_valid_q && (burst_len != '0)) begin
                    remain_d = burst_len;
                    burst_d  = 1'b1;
                    encdec_d = 1'b1;
                    state_d  = StFetch;
                end else if (key_valid_q && !burst_start) begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        block_d  = cmd_block;
                        encdec_d = cmd_encdec;
                        state_d  = StStart;
                    end
                end
            end
            StKinit: state_d = StKwait;
            // First wait cycle may still see the core's pre-command ready/valid level.
            StKwait: begin
                if (!first_q && core_ready) begin
                    key_valid_d = 1'b1;
                    state_d     = StIdle;
                end else if (wd_expire) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StFetch: state_d = StRcap;
            StRcap: begin
                block_d = rnd_data;
                state_d = StStart;
            end
            StStart: state_d = StBwait;
            StBwait: begin
                if (!first_q && core_valid) begin
                    res_d   = core_result;
                    state_d = StResult;
                end else if (wd_expire) begin
                    err_d       = 1'b1;
                    key_valid_d = 1'b0;
                    burst_d     = 1'b0;
                    remain_d    = '0;
                    state_d     = StIdle;
                end
            end
            StResult: begin
                if (res_ready) begin
                    blk_cnt_d = blk_cnt_q + CNT_W'(1);
                    state_d   = StIdle;
                    if (burst_q) begin
                        remain_d = remain_q - CNT_W'(1);
                        if (remain_d != '0) begin
                            state_d = StFetch;
                        end else begin
                            burst_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            first_q     <= 1'b0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            burst_q     <= 1'b0;
            remain_q    <= '0;
            blk_cnt_q   <= '0;
            encdec_q    <= 1'b0;
            key_q       <= '0;
            block_q     <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= (state_d != state_q);
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            burst_q     <= burst_d;
            remain_q    <= remain_d;
            blk_cnt_q   <= blk_cnt_d;
            encdec_q    <= encdec_d;
            key_q       <= key_d;
            block_q     <= block_d;
            res_q       <= res_d;
        end
    end

    assign core_init   = (state_q == StKinit);
    assign core_next   = (state_q == StStart);
    assign rnd_req     = (state_q == StFetch);
    assign res_valid   = (state_q == StResult);
    assign busy        = (state_q != StIdle);
    assign core_encdec = encdec_q;
    assign core_key    = key_q;
    assign core_block  = block_q;
    assign res_data    = res_q;
    assign key_valid   = key_valid_q;
    assign blk_cnt     = blk_cnt_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Randomized bench for aes_core_sequencer: behavioural AES core and LFSR models plus a
// scoreboard computing every expected result from the loaded key and offered blocks.
`timescale 1ns/1ps
module tb_aes_core_sequencer;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TO_W    = 8;
    localparam int unsigned TIMEOUT = 40;

    localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_load = 1'b0;
    logic [127:0]     key = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [127:0]     cmd_block = '0;
    logic             cmd_encdec = 1'b0;
    logic             burst_start = 1'b0;
    logic [CNT_W-1:0] burst_len = '0;
    logic             rnd_req;
    logic [127:0]     rnd_data;
    logic             core_init, core_next, core_encdec;
    logic [127:0]     core_key, core_block;
    logic             core_ready, core_valid;
    logic [127:0]     core_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [127:0]     res_data;
    logic             busy, key_valid, err_timeout;
    logic [CNT_W-1:0] blk_cnt;

    always #5 clk = ~clk;

    aes_core_sequencer #(
        .CNT_W   (CNT_W),
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_load    (key_load),
        .key         (key),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_block   (cmd_block),
        .cmd_encdec  (cmd_encdec),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .rnd_req     (rnd_req),
        .rnd_data    (rnd_data),
        .core_init   (core_init),
        .core_next   (core_next),
        .core_encdec (core_encdec),
        .core_key    (core_key),
        .core_block  (core_block),
        .core_ready  (core_ready),
        .core_valid  (core_valid),
        .core_result (core_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .key_valid   (key_valid),
        .blk_cnt     (blk_cnt),
        .err_timeout (err_timeout)
    );

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [127:0] exp_q[$];
    logic [127:0] cur_key = '0;
    int           exp_cnt = 0;
    int           init_pulses = 0;
    int           rnd_pulses = 0;
    int           overlap = 0;
    bit           rnd_pend = 1'b0;
    bit           auto_rdy = 1'b1;
    bit           man_rdy = 1'b0;
    bit           hang = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] x, r, t;
            x = 8'(v); r = 8'h01; t = x;
            for (int i = 0; i < 7; i++) begin
                t = gm(t, t);
                r = gm(r, t);
            end
            if (x == 8'h00) r = 8'h00;
            t = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
                ^ 8'h63;
            sbox_t[v]  = t;
            isbox_t[t] = x;
        end
    endtask

    function automatic logic [1407:0] kexp(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!inv) o[127-8*(r+4*c) -: 8] = sbox_t[s[127-8*(r+4*((c+r)%4)) -: 8]];
                else      o[127-8*(r+4*((c+r)%4)) -: 8] = isbox_t[s[127-8*(r+4*c) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   b;
        if (inv) begin
            m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
        end else begin
            m[0] = 8'd2; m[1] = 8'd3; m[2] = 8'd1; m[3] = 8'd1;
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                b = '0;
                for (int k = 0; k < 4; k++) b = b ^ gm(m[(k-j+4)%4], s[127-8*(k+4*c) -: 8]);
                o[127-8*(j+4*c) -: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] k, input logic [127:0] blk,
                                         input logic enc);
        logic [1407:0] rk;
        logic [127:0]  s;
        rk = kexp(k);
        if (enc) begin
            s = blk ^ rk[0 +: 128];
            for (int r = 1; r < 10; r++) s = mix(sub_shift(s, 1'b0), 1'b0) ^ rk[128*r +: 128];
            s = sub_shift(s, 1'b0) ^ rk[1280 +: 128];
        end else begin
            s = blk ^ rk[1280 +: 128];
            for (int r = 9; r >= 1; r--) s = mix(sub_shift(s, 1'b1) ^ rk[128*r +: 128], 1'b1);
            s = sub_shift(s, 1'b1) ^ rk[0 +: 128];
        end
        return s;
    endfunction

    // ---------------- aes_core and lfsr models ----------------
    logic         m_ready, m_valid, m_busy, m_is_next;
    logic [127:0] m_result, m_pend, m_key;
    int unsigned  m_cnt;

    assign core_ready  = m_ready;
    assign core_valid  = m_valid;
    assign core_result = m_result;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_busy <= 1'b0; m_is_next <= 1'b0;
            m_result <= '0; m_pend <= '0; m_key <= '0; m_cnt <= 0; rnd_data <= '0;
        end else begin
            rnd_data <= {$urandom, $urandom, $urandom, $urandom};
            if (core_init) begin
                m_key <= core_key; m_ready <= 1'b0; m_valid <= 1'b0;
                m_busy <= 1'b1; m_is_next <= 1'b0; m_cnt <= $urandom_range(2, 12);
            end else if (core_next) begin
                m_pend <= aes(m_key, core_block, core_encdec);
                m_ready <= 1'b0; m_valid <= 1'b0;
                m_busy <= 1'b1; m_is_next <= 1'b1; m_cnt <= $urandom_range(2, 12);
            end else if (m_busy && !(hang && !m_is_next)) begin
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                    if (m_is_next) begin
                        m_valid  <= 1'b1;
                        m_result <= m_pend;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        res_ready = auto_rdy ? ($urandom_range(0, 2) != 0) : man_rdy;
    end

    // Scoreboard: expected results come from the loaded key and the blocks offered.
    initial forever begin
        @(negedge clk);
        if (core_init) init_pulses++;
        if (core_init && core_next) overlap++;
        if (rnd_pend) begin
            exp_q.push_back(aes(cur_key, rnd_data, 1'b1));
            rnd_pend = 1'b0;
        end
        if (rnd_req) begin
            rnd_pulses++;
            rnd_pend = 1'b1;
        end
        if (cmd_valid && cmd_ready) exp_q.push_back(aes(cur_key, cmd_block, cmd_encdec));
        if (res_valid && res_ready) begin
            check_eq("res_pending", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) check_eq("res_data", res_data, exp_q.pop_front());
            exp_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq(tag, 128'(busy), 128'd0);
        tick(1);
    endtask

    task automatic wait_res(input string tag, input int lim);
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        check_eq(tag, 128'(res_valid), 128'd1);
    endtask

    task automatic load_key(input logic [127:0] k);
        cur_key  = k;
        key      = k;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic send_cmd(input logic [127:0] b, input logic e);
        bit acc;
        acc = 1'b0;
        cmd_block = b; cmd_encdec = e; cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_ready;
            tick(1);
        end
        cmd_valid = 1'b0;
        check_eq("cmd_accept", 128'(acc), 128'd1);
    endtask

    task automatic run_burst(input int n);
        burst_len   = CNT_W'(n);
        burst_start = 1'b1;
        tick(1);
        burst_start = 1'b0;
        wait_idle("burst_done", 100 * n + 50);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  r0, n0, cyc, bad;
        bit  found;
        build_sbox();
        tick(3);
        check_eq("rst_ctrl", 128'({busy, key_valid, err_timeout, res_valid, cmd_ready,
                                   core_init, core_next, rnd_req, core_encdec}), 128'd0);
        check_eq("rst_blk_cnt", 128'(blk_cnt), 128'd0);
        check_eq("rst_core_key", core_key, 128'd0);
        check_eq("rst_res_data", res_data, 128'd0);
        rst_n = 1'b1;
        tick(2);

        cmd_block = FipsPt; cmd_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_ready || busy) bad++;
            tick(1);
        end
        cmd_valid = 1'b0;
        check_eq("cmd_ready_without_key", 128'(bad), 128'd0);

        n0 = init_pulses;
        load_key(FipsKey);
        wait_idle("key_expand", 100);
        check_eq("init_pulses", 128'(init_pulses - n0), 128'd1);
        check_eq("key_valid_after_init", 128'(key_valid), 128'd1);

        send_cmd(FipsPt, 1'b1);
        wait_res("fips_enc_res_valid", 100);
        check_eq("fips_enc_data", res_data, FipsCt);
        wait_idle("fips_enc_done", 100);
        check_eq("blk_cnt_after_enc", 128'(blk_cnt), 128'd1);

        auto_rdy = 1'b0; man_rdy = 1'b0;
        send_cmd(FipsCt, 1'b0);
        wait_res("fips_dec_res_valid", 100);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!res_valid || cmd_ready || res_data !== FipsPt) bad++;
        end
        check_eq("stall_hold", 128'(bad), 128'd0);
        check_eq("fips_dec_data", res_data, FipsPt);
        man_rdy = 1'b1; auto_rdy = 1'b1;
        wait_idle("fips_dec_done", 100);
        check_eq("blk_cnt_after_dec", 128'(blk_cnt), 128'd2);

        for (int i = 0; i < 16; i++) begin
            send_cmd({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
        end
        wait_idle("host_random_done", 200);
        check_eq("blk_cnt_host_random", 128'(blk_cnt), 128'(exp_cnt));

        r0 = rnd_pulses;
        run_burst(3);
        check_eq("burst3_rnd_req", 128'(rnd_pulses - r0), 128'd3);
        check_eq("burst3_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));

        r0 = rnd_pulses;
        burst_len = '0; burst_start = 1'b1;
        tick(1);
        burst_start = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) bad++;
        end
        tick(1);
        check_eq("burst0_idle", 128'(bad), 128'd0);
        check_eq("burst0_rnd_req", 128'(rnd_pulses - r0), 128'd0);

        load_key({$urandom, $urandom, $urandom, $urandom});
        wait_idle("key_random", 100);
        check_eq("blk_cnt_cleared", 128'(blk_cnt), 128'd0);
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                r0 = rnd_pulses;
                n0 = $urandom_range(1, 4);
                run_burst(n0);
                check_eq("burst_rand_rnd_req", 128'(rnd_pulses - r0), 128'(n0));
            end else begin
                send_cmd({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
                wait_idle("host_mix_done", 100);
            end
        end
        check_eq("blk_cnt_mix", 128'(blk_cnt), 128'(exp_cnt));

        hang = 1'b1;
        load_key({$urandom, $urandom, $urandom, $urandom});
        cyc = 0;
        for (int k = 0; k < int'(TIMEOUT) + 50; k++) begin
            @(negedge clk);
            cyc++;
            if (err_timeout) break;
        end
        check_eq("timeout_err", 128'(err_timeout), 128'd1);
        check_eq("timeout_window", 128'(cyc >= int'(TIMEOUT) && cyc <= int'(TIMEOUT) + 3),
                 128'd1);
        check_eq("timeout_key_valid", 128'(key_valid), 128'd0);
        check_eq("timeout_idle", 128'(busy), 128'd0);
        tick(1);

        r0 = rnd_pulses;
        burst_len = CNT_W'(2); burst_start = 1'b1; cmd_valid = 1'b1;
        tick(1);
        burst_start = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || cmd_ready) bad++;
        end
        tick(1);
        cmd_valid = 1'b0;
        check_eq("no_key_ignored", 128'(bad), 128'd0);
        check_eq("no_key_rnd_req", 128'(rnd_pulses - r0), 128'd0);

        hang = 1'b0;
        load_key(FipsKey);
        wait_idle("key_recover", 100);
        check_eq("err_cleared", 128'(err_timeout), 128'd0);
        check_eq("key_valid_recover", 128'(key_valid), 128'd1);

        cmd_block = FipsPt; cmd_encdec = 1'b1; cmd_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (core_next) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("bwait_reached", 128'(found), 128'd1);
        tick(1);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_bwait_ctrl", 128'({busy, key_valid, err_timeout, res_valid, cmd_ready,
                                         core_init, core_next, rnd_req, core_encdec}), 128'd0);
        check_eq("rst_bwait_blk_cnt", 128'(blk_cnt), 128'd0);
        check_eq("rst_bwait_core_block", core_block, 128'd0);
        check_eq("rst_bwait_core_key", core_key, 128'd0);
        exp_q.delete();
        rnd_pend = 1'b0;
        exp_cnt = 0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        check_eq("init_next_overlap", 128'(overlap), 128'd0);
        check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
